ddr3_burst_reader: RTL

DDR3_BURST_READER -- requirements
Module: ddr3_burst_reader

---
 rtl/ddr3_burst_reader_pkg.sv | 30 +++
 rtl/ddr3_burst_reader_if.sv | 46 ++++
 rtl/ddr3_burst_reader_sc_fifo.sv | 58 +++++
 rtl/ddr3_burst_reader.sv | 176 +++++++++++++++++
 4 files changed

// File: rtl/ddr3_burst_reader_pkg.sv
// Shared types for the DDR3 burst reader: FSM states, command field widths,
// the per-burst tag carried from issue to return, and the buffered output word.
package ddr3_rd_pkg;

    localparam int ADDR_W  = 27;
    localparam int THIRD_W = 2;
    localparam int LEN_W   = 5;
    localparam int CMD_W   = THIRD_W + ADDR_W;
    localparam int DATA_W  = 256;
    localparam int STAT_W  = 32;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_CREDIT,
        ST_ISSUE,
        ST_NEXT
    } state_t;

    typedef struct packed {
        logic [THIRD_W-1:0] third;
        logic [LEN_W-1:0]   len;
    } tag_t;

    typedef struct packed {
        logic [DATA_W-1:0]  data;
        logic [THIRD_W-1:0] third;
        logic               last;
    } word_t;

endpackage

// File: rtl/ddr3_burst_reader_if.sv
// Command, Avalon-MM read master, output stream and statistics signals of the
// burst reader; slave is the reader's view, master the environment's view.
interface ddr3_burst_reader_if;
    import ddr3_rd_pkg::*;

    logic [CMD_W-1:0]   cmd_data;
    logic               cmd_valid;
    logic               cmd_ready;

    logic [ADDR_W-1:0]  avm_address;
    logic               avm_read;
    logic [LEN_W-1:0]   avm_burstcount;
    logic               avm_waitrequest;
    logic [DATA_W-1:0]  avm_readdata;
    logic               avm_readdatavalid;

    logic [DATA_W-1:0]  out_data;
    logic [THIRD_W-1:0] out_third;
    logic               out_last;
    logic               out_valid;
    logic               out_ready;

    logic [STAT_W-1:0]  stat_bursts;
    logic [STAT_W-1:0]  stat_stall_cycles;

    modport slave (
        input  cmd_data, cmd_valid,
        output cmd_ready,
        output avm_address, avm_read, avm_burstcount,
        input  avm_waitrequest, avm_readdata, avm_readdatavalid,
        output out_data, out_third, out_last, out_valid,
        input  out_ready,
        output stat_bursts, stat_stall_cycles
    );

    modport master (
        output cmd_data, cmd_valid,
        input  cmd_ready,
        input  avm_address, avm_read, avm_burstcount,
        output avm_waitrequest, avm_readdata, avm_readdatavalid,
        input  out_data, out_third, out_last, out_valid,
        output out_ready,
        input  stat_bursts, stat_stall_cycles
    );

endinterface

// File: rtl/ddr3_burst_reader_sc_fifo.sv
// Single-clock first-word-fall-through FIFO with full/empty/used-word count.
// DEPTH must be a power of two; a push while full is dropped and asserted on.
module sc_fifo #(
    parameter int WIDTH = 8,
    parameter int DEPTH = 16,
    localparam int AW   = $clog2(DEPTH)
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             push,
    input  logic [WIDTH-1:0] wr_data,
    input  logic             pop,
    output logic [WIDTH-1:0] rd_data,
    output logic             full,
    output logic             empty,
    output logic [AW:0]      usedw
);

    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [AW:0]      wr_ptr_q, wr_ptr_d;
    logic [AW:0]      rd_ptr_q, rd_ptr_d;
    logic             do_push, do_pop;

    assign usedw   = wr_ptr_q - rd_ptr_q;
    assign full    = (usedw == (AW+1)'(DEPTH));
    assign empty   = (usedw == '0);
    assign do_push = push & ~full;
    assign do_pop  = pop & ~empty;
    assign rd_data = mem_q[rd_ptr_q[AW-1:0]];

    always_comb begin
        // NOTE: every output of this block gets a default first, so no path can infer a latch.
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        if (do_push) wr_ptr_d = wr_ptr_q + (AW+1)'(1);
        if (do_pop)  rd_ptr_d = rd_ptr_q + (AW+1)'(1);
    end

    // NOTE: state flops use non-blocking assignment so all of them update together at the edge.
    always_ff @(posedge clk) begin
        if (reset) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
        end
    end

    // NOTE: storage is not reset; the pointers alone say which entries are valid, so it can map to RAM.
    always_ff @(posedge clk) begin
        if (do_push) mem_q[wr_ptr_q[AW-1:0]] <= wr_data;
    end

    overflow_a: assert property (@(posedge clk) disable iff (reset) !(push && full))
        else $error("sc_fifo overflow");

endmodule

// File: rtl/ddr3_burst_reader.sv
// Reads ROWS rows of one screen third as Avalon bursts, reserving output FIFO
// space before each issue. Define DDR3_RD_STATS_EN to enable burst/stall counters.
module ddr3_burst_reader
    import ddr3_rd_pkg::*;
#(
    parameter int THIRD_WORDS     = 15,
    parameter int CENTER_WORDS    = 19,
    parameter int ROW_STRIDE      = 48,
    parameter int ROWS            = 480,
    parameter int FIFO_DEPTH      = 256,
    parameter int MAX_OUTSTANDING = 8
) (
    input  logic clk,
    input  logic reset,
    ddr3_burst_reader_if.slave bus
);

    localparam int CW    = $clog2(FIFO_DEPTH) + 1;
    localparam int ROW_W = (ROWS > 1) ? $clog2(ROWS) : 1;
    localparam int TAG_AW  = $clog2(MAX_OUTSTANDING);
    localparam int DATA_AW = $clog2(FIFO_DEPTH);

    state_t             state_q, state_d;
    logic [THIRD_W-1:0] third_q, third_d;
    logic [ADDR_W-1:0]  base_q, base_d;
    logic [ROW_W-1:0]   row_q, row_d;
    logic [LEN_W-1:0]   len_q, len_d;
    logic [CW-1:0]      credits_q, credits_d;
    logic [LEN_W-1:0]   beat_cnt_q, beat_cnt_d;

    logic               cmd_ready_c;
    logic               accept, data_pop, beat_ok, beat_last;
    logic [ADDR_W-1:0]  row_off;
    tag_t               tag_in, tag_head;
    logic               tag_full, tag_empty;
    logic [TAG_AW:0]    tag_usedw;
    word_t              data_in, data_head;
    logic               data_full, data_empty;
    logic [DATA_AW:0]   data_usedw;

    assign row_off            = ADDR_W'(row_q) * ADDR_W'(ROW_STRIDE);
    assign bus.avm_address    = base_q + row_off;
    assign bus.avm_burstcount = len_q;
    assign bus.cmd_ready      = cmd_ready_c & ~reset;

    assign accept    = bus.avm_read & ~bus.avm_waitrequest;
    assign data_pop  = bus.out_valid & bus.out_ready;
    assign beat_ok   = bus.avm_readdatavalid & ~tag_empty;
    assign beat_last = beat_ok && (beat_cnt_q == tag_head.len - LEN_W'(1));

    always_comb begin
        state_d      = state_q;
        third_d      = third_q;
        base_d       = base_q;
        row_d        = row_q;
        len_d        = len_q;
        cmd_ready_c  = 1'b0;
        bus.avm_read = 1'b0;
        case (state_q)
            ST_IDLE: begin
                cmd_ready_c = 1'b1;
                if (bus.cmd_valid) begin
                    third_d = bus.cmd_data[CMD_W-1 -: THIRD_W];
                    base_d  = bus.cmd_data[ADDR_W-1:0];
                    row_d   = '0;
                    len_d   = (third_d == THIRD_W'(1)) ? LEN_W'(CENTER_WORDS) : LEN_W'(THIRD_WORDS);
                    state_d = ST_CREDIT;
                end
            end
            ST_CREDIT: begin
                if (credits_q >= CW'(len_q) && !tag_full) state_d = ST_ISSUE;
            end
            ST_ISSUE: begin
                bus.avm_read = 1'b1;
                if (!bus.avm_waitrequest) state_d = ST_NEXT;
            end
            ST_NEXT: begin
                if (row_q == ROW_W'(ROWS - 1)) begin
                    state_d = ST_IDLE;
                end else begin
                    row_d   = row_q + ROW_W'(1);
                    state_d = ST_CREDIT;
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    // A credit is one free output FIFO word; a burst reserves its whole length at issue.
    always_comb begin
        credits_d  = credits_q + CW'(data_pop) - (accept ? CW'(len_q) : CW'(0));
        beat_cnt_d = beat_cnt_q;
        if (beat_ok) beat_cnt_d = beat_last ? '0 : beat_cnt_q + LEN_W'(1);
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q    <= ST_IDLE;
            third_q    <= '0;
            base_q     <= '0;
            row_q      <= '0;
            len_q      <= '0;
            credits_q  <= CW'(FIFO_DEPTH);
            beat_cnt_q <= '0;
        end else begin
            state_q    <= state_d;
            third_q    <= third_d;
            base_q     <= base_d;
            row_q      <= row_d;
            len_q      <= len_d;
            credits_q  <= credits_d;
            beat_cnt_q <= beat_cnt_d;
        end
    end

    assign tag_in = '{third: third_q, len: len_q};

    sc_fifo #(.WIDTH($bits(tag_t)), .DEPTH(MAX_OUTSTANDING)) u_tag_fifo (
        .clk(clk), .reset(reset),
        .push(accept), .wr_data(tag_in), .pop(beat_last),
        .rd_data(tag_head), .full(tag_full), .empty(tag_empty), .usedw(tag_usedw)
    );

    assign data_in = '{data: bus.avm_readdata, third: tag_head.third, last: beat_last};

    sc_fifo #(.WIDTH($bits(word_t)), .DEPTH(FIFO_DEPTH)) u_data_fifo (
        .clk(clk), .reset(reset),
        .push(beat_ok), .wr_data(data_in), .pop(data_pop),
        .rd_data(data_head), .full(data_full), .empty(data_empty), .usedw(data_usedw)
    );

    assign bus.out_valid = ~data_empty;
    assign bus.out_data  = data_head.data;
    assign bus.out_third = data_head.third;
    assign bus.out_last  = data_head.last;

    credit_a: assert property (@(posedge clk) disable iff (reset)
        32'(credits_q) + 32'(data_usedw) <= 32'(FIFO_DEPTH))
        else $error("credit accounting exceeds data FIFO depth");
    beat_idle_a: assert property (@(posedge clk) disable iff (reset)
        (tag_usedw == '0) |-> (beat_cnt_q == '0))
        else $error("beat counter nonzero with no burst outstanding");
    no_full_write_a: assert property (@(posedge clk) disable iff (reset) !(beat_ok && data_full))
        else $error("data FIFO written while full");

`ifdef DDR3_RD_STATS_EN
    logic              stall;
    logic [STAT_W-1:0] bursts_q, bursts_d, stalls_q, stalls_d;

    assign stall = bus.avm_read & bus.avm_waitrequest;

    always_comb begin
        bursts_d = bursts_q;
        stalls_d = stalls_q;
        if (accept && bursts_q != '1) bursts_d = bursts_q + STAT_W'(1);
        if (stall && stalls_q != '1)  stalls_d = stalls_q + STAT_W'(1);
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            bursts_q <= '0;
            stalls_q <= '0;
        end else begin
            bursts_q <= bursts_d;
            stalls_q <= stalls_d;
        end
    end

    assign bus.stat_bursts       = bursts_q;
    assign bus.stat_stall_cycles = stalls_q;
`else
    assign bus.stat_bursts       = '0;
    assign bus.stat_stall_cycles = '0;
`endif

endmodule
